// File: rtl/adc_sample_buffer.sv
// Sample post-processing for the SAR ADC peripheral: optional 2^k boxcar averaging,
// window compare and a first-word-fall-through result FIFO drained from the bus side.
module adc_sample_buffer #(
   parameter int unsigned DW           = 12,
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned MAX_AVG_LOG2 = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  en,
   input  logic                  flush,
   input  logic [2:0]            avg_log2,
   input  logic [DW-1:0]         thr_lo,
   input  logic [DW-1:0]         thr_hi,
   input  logic                  s_valid,
   input  logic [DW-1:0]         s_data,
   input  logic                  rd_en,
   output logic [DW-1:0]         rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  ovf,
   output logic                  win_evt
);

   localparam int unsigned AW    = DW + MAX_AVG_LOG2;
   localparam int unsigned CW    = MAX_AVG_LOG2 + 1;
   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [2:0]  MaxK  = 3'(MAX_AVG_LOG2);
   localparam logic [DEPTH_LOG2:0] LvlFull = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2:0] LvlOne  = (DEPTH_LOG2 + 1)'(1);

   logic [AW-1:0]         acc_q;
   logic [AW-1:0]         acc_sum;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         cnt_last;
   logic [2:0]            k_q;
   logic [2:0]            k_req;
   logic [2:0]            k_cur;
   logic [DW-1:0]         res_q;
   logic                  res_v_q;
   logic [DW-1:0]         mem [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  ovf_q;
   logic                  accept;
   logic                  last;
   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  fifo_full;

   always_comb begin
      k_req      = (avg_log2 > MaxK) ? MaxK : avg_log2;
      // The first sample of a block uses the live exponent; later ones use the latched copy.
      k_cur      = (cnt_q == '0) ? k_req : k_q;
      cnt_last   = CW'((32'd1 << k_cur) - 32'd1);
      accept     = en & s_valid & ~flush;
      last       = accept & (cnt_q == cnt_last);
      acc_sum    = acc_q + AW'(s_data);
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == LvlFull);
      pop        = rd_en & ~fifo_empty & ~flush;
      push       = res_v_q & ~flush & (~fifo_full | pop);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         res_q   <= '0;
         res_v_q <= 1'b0;
      end else begin
         res_v_q <= last;
         if (flush || !en) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (accept) begin
            if (cnt_q == '0) begin
               k_q <= k_req;
            end
            if (last) begin
               acc_q <= '0;
               cnt_q <= '0;
               res_q <= DW'(acc_sum >> k_cur);
            end else begin
               acc_q <= acc_sum;
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LvlOne;
         end else if (pop && !push) begin
            level_q <= level_q - LvlOne;
         end
         // A completed result that could not be written is a drop.
         if (res_v_q && !push) begin
            ovf_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= res_q;
      end
   end

   always_comb begin
      rd_valid = ~fifo_empty;
      rd_data  = fifo_empty ? '0 : mem[rd_ptr_q];
      level    = level_q;
      full     = fifo_full;
      ovf      = ovf_q;
      win_evt  = res_v_q & ~flush & (thr_lo <= thr_hi) & ((res_q < thr_lo) | (res_q > thr_hi));
   end

endmodule
